// File: rtl/fpu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_seq
// Brief    : Holds one FP op on the ALU inputs for its fixed latency, then
//            emits a one-cycle write-back. Define FPU_SEQ_FLAGS_EN to add
//            the flags[3:0] result-classification output.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_seq #(
    parameter int LAT_ADD  = 1,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 16
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_dst,
    input  logic        flush,
    output logic        issue_ready,
    output logic        busy,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal_op
`ifdef FPU_SEQ_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_EXEC = 2'd1;
    localparam logic [1:0]  S_WB   = 2'd2;

    localparam logic [31:0] c_qnan      = 32'h7FC0_0000;
    localparam logic [4:0]  c_cnt_add   = 5'(LAT_ADD  - 1);
    localparam logic [4:0]  c_cnt_mul   = 5'(LAT_MUL  - 1);
    localparam logic [4:0]  c_cnt_div   = 5'(LAT_DIV  - 1);
    localparam logic [4:0]  c_cnt_sqrt  = 5'(LAT_SQRT - 1);

    logic [1:0] r_state;
    logic [4:0] r_cnt;
    logic [4:0] r_dst;
    logic       w_accept;
    logic       w_legal;
    logic [4:0] w_cnt_init;

    assign issue_ready = (r_state != S_EXEC) && !flush;
    assign busy        = (r_state == S_EXEC);
    assign w_accept    = issue_valid && issue_ready;
    assign w_legal     = !issue_op[2];

    always_comb begin
        w_cnt_init = c_cnt_add;
        case (issue_op[1:0])
            2'd0:    w_cnt_init = c_cnt_add;
            2'd1:    w_cnt_init = c_cnt_mul;
            2'd2:    w_cnt_init = c_cnt_div;
            default: w_cnt_init = c_cnt_sqrt;
        endcase
    end

`ifdef FPU_SEQ_FLAGS_EN
    // {invalid, overflow, zero} classification of a write-back value
    function automatic logic [2:0] f_class(input logic [31:0] v);
        return {(&v[30:23]) && (|v[22:0]), (&v[30:23]) && !(|v[22:0]), !(|v[30:0])};
    endfunction
`endif

    always_ff @(posedge cpu_clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_dst      <= 5'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_sel    <= 3'd0;
            wb_valid   <= 1'b0;
            wb_addr    <= 5'd0;
            wb_data    <= 32'd0;
            illegal_op <= 1'b0;
`ifdef FPU_SEQ_FLAGS_EN
            flags      <= 4'd0;
`endif
        end else begin
            wb_valid   <= 1'b0;
            illegal_op <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
                r_cnt   <= 5'd0;
            end else if (w_accept) begin
                alu_a   <= issue_a;
                alu_b   <= issue_b;
                alu_sel <= issue_op;
                r_dst   <= issue_dst;
                if (w_legal) begin
                    r_state <= S_EXEC;
                    r_cnt   <= w_cnt_init;
                end else begin
                    // Illegal selectors bypass the ALU and return a quiet NaN
                    r_state    <= S_WB;
                    r_cnt      <= 5'd0;
                    wb_valid   <= 1'b1;
                    illegal_op <= 1'b1;
                    wb_addr    <= issue_dst;
                    wb_data    <= c_qnan;
`ifdef FPU_SEQ_FLAGS_EN
                    flags      <= {f_class(c_qnan), 1'b1};
`endif
                end
            end else if (r_state == S_EXEC) begin
                if (r_cnt != 5'd0) begin
                    r_cnt <= r_cnt - 5'd1;
                end else begin
                    r_state  <= S_WB;
                    wb_valid <= 1'b1;
                    wb_addr  <= r_dst;
                    wb_data  <= alu_result;
`ifdef FPU_SEQ_FLAGS_EN
                    flags    <= {f_class(alu_result), 1'b0};
`endif
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_seq
// Brief    : Directed bench for fpu_issue_seq with a timestamp-based model
//            and a stub ALU. Flags checks are built with FPU_SEQ_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_seq;

    localparam int          c_lat_add  = 1;
    localparam int          c_lat_mul  = 2;
    localparam int          c_lat_div  = 12;
    localparam int          c_lat_sqrt = 16;
    localparam logic [31:0] c_qnan     = 32'h7FC0_0000;

    logic        cpu_clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_dst;
    logic        flush;
    logic        issue_ready;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal_op;
`ifdef FPU_SEQ_FLAGS_EN
    logic [3:0]  flags;
`endif

    int checks   = 0;
    int failures = 0;

    fpu_issue_seq #(
        .LAT_ADD (c_lat_add),
        .LAT_MUL (c_lat_mul),
        .LAT_DIV (c_lat_div),
        .LAT_SQRT(c_lat_sqrt)
    ) dut (
        .cpu_clk    (cpu_clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_op   (issue_op),
        .issue_a    (issue_a),
        .issue_b    (issue_b),
        .issue_dst  (issue_dst),
        .flush      (flush),
        .issue_ready(issue_ready),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .illegal_op (illegal_op)
`ifdef FPU_SEQ_FLAGS_EN
        ,
        .flags      (flags)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    // Stub ALU: known IEEE-754 vectors, otherwise an arbitrary mix of inputs
    function automatic logic [31:0] alu_fn(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (sel == 3'd1 && a == 32'h4040_0000 && b == 32'h4000_0000) return 32'h40C0_0000;
        if (sel == 3'd1 && a == 32'h7F00_0000 && b == 32'h4000_0000) return 32'h7F80_0000;
        if (sel == 3'd2 && a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (sel == 3'd3 && a == 32'h4080_0000) return 32'h4000_0000;
        if (sel == 3'd3 && a == 32'hBF80_0000) return c_qnan;
        return a ^ {b[15:0], b[31:16]} ^ {29'd0, sel};
    endfunction

    assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'd0:    return c_lat_add;
            3'd1:    return c_lat_mul;
            3'd2:    return c_lat_div;
            default: return c_lat_sqrt;
        endcase
    endfunction

    function automatic logic [3:0] classify(input logic [31:0] v, input logic ill);
        logic exp_ones;
        exp_ones = (v[30:23] == 8'hFF);
        return {exp_ones && (v[22:0] != 23'd0), exp_ones && (v[22:0] == 23'd0), v[30:0] == 31'd0, ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an op in flight is just its accept timestamp and latency
    int          cyc = 0;
    bit          m_started = 1'b0;
    bit          m_have;
    int          m_acc;
    int          m_lat;
    logic [4:0]  m_dst;
    logic [31:0] m_alu_a, m_alu_b;
    logic [2:0]  m_alu_sel;
    logic        m_wb_valid, m_illegal;
    logic [4:0]  m_wb_addr;
    logic [31:0] m_wb_data;
    logic [3:0]  m_flags;

    always @(posedge cpu_clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_started  <= 1'b1;
            m_have     <= 1'b0;
            m_alu_a    <= 32'd0;
            m_alu_b    <= 32'd0;
            m_alu_sel  <= 3'd0;
            m_wb_valid <= 1'b0;
            m_illegal  <= 1'b0;
            m_wb_addr  <= 5'd0;
            m_wb_data  <= 32'd0;
            m_flags    <= 4'd0;
        end else begin
            m_wb_valid <= 1'b0;
            m_illegal  <= 1'b0;
            if (flush) begin
                m_have <= 1'b0;
            end else if (issue_valid && !m_have) begin
                m_alu_a   <= issue_a;
                m_alu_b   <= issue_b;
                m_alu_sel <= issue_op;
                if (issue_op >= 3'd4) begin
                    m_wb_valid <= 1'b1;
                    m_illegal  <= 1'b1;
                    m_wb_addr  <= issue_dst;
                    m_wb_data  <= c_qnan;
                    m_flags    <= classify(c_qnan, 1'b1);
                end else begin
                    m_have <= 1'b1;
                    m_acc  <= cyc;
                    m_lat  <= lat_of(issue_op);
                    m_dst  <= issue_dst;
                end
            end else if (m_have && cyc == m_acc + m_lat) begin
                m_have     <= 1'b0;
                m_wb_valid <= 1'b1;
                m_wb_addr  <= m_dst;
                m_wb_data  <= alu_fn(m_alu_sel, m_alu_a, m_alu_b);
                m_flags    <= classify(alu_fn(m_alu_sel, m_alu_a, m_alu_b), 1'b0);
            end
        end
    end

    int wb_times[$];

    always @(negedge cpu_clk) begin
        if (m_started) begin
            chk("issue_ready", 32'(issue_ready), 32'(!m_have && !flush));
            chk("busy", 32'(busy), 32'(m_have));
            chk("alu_a", alu_a, m_alu_a);
            chk("alu_b", alu_b, m_alu_b);
            chk("alu_sel", 32'(alu_sel), 32'(m_alu_sel));
            chk("wb_valid", 32'(wb_valid), 32'(m_wb_valid));
            chk("illegal_op", 32'(illegal_op), 32'(m_illegal));
            if (m_wb_valid) begin
                chk("wb_addr", 32'(wb_addr), 32'(m_wb_addr));
                chk("wb_data", wb_data, m_wb_data);
`ifdef FPU_SEQ_FLAGS_EN
                chk("flags", 32'(flags), 32'(m_flags));
`endif
            end
            if (wb_valid) wb_times.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        issue_dst   = dst;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic wait_wb(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge cpu_clk);
            if (wb_valid) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit got;
        int nbusy;
        rst_n = 1'b0; issue_valid = 1'b0; issue_op = 3'd0;
        issue_a = 32'd0; issue_b = 32'd0; issue_dst = 5'd0; flush = 1'b0;
        tick(); tick();
        @(negedge cpu_clk);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Add: single-cycle latency
        issue(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd7);
        @(negedge cpu_clk);
        chk("add_alu_a", alu_a, 32'h3F80_0000);
        wait_wb(4, got);
        chk("add_wb_seen", 32'(got), 32'd1);
        chk("add_wb_data", wb_data, 32'h4040_0000);
        chk("add_wb_addr", 32'(wb_addr), 32'd7);
        tick();

        // Div with a held follow-up add that must wait for the WB cycle
        issue_valid = 1'b1; issue_op = 3'd2; issue_a = 32'h40C0_0000; issue_b = 32'h4000_0000; issue_dst = 5'd3;
        tick();
        issue_op = 3'd0; issue_a = 32'h3F80_0000; issue_b = 32'h4000_0000; issue_dst = 5'd4;
        nbusy = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge cpu_clk);
            if (wb_valid) got = 1'b1;
            else if (busy) nbusy++;
        end
        chk("div_wb_seen", 32'(got), 32'd1);
        chk("div_busy_cycles", 32'(nbusy), 32'd12);
        chk("div_wb_data", wb_data, 32'h4040_0000);
        chk("div_sel_held", 32'(alu_sel), 32'd2);
        tick();
        issue_valid = 1'b0;
        @(negedge cpu_clk);
        chk("div_next_sel", 32'(alu_sel), 32'd0);
        tick(); tick();

        // Back-to-back mul then add
        wb_times.delete();
        issue_valid = 1'b1; issue_op = 3'd1; issue_a = 32'h4040_0000; issue_b = 32'h4000_0000; issue_dst = 5'd9;
        tick();
        issue_op = 3'd0; issue_a = 32'h3F80_0000; issue_b = 32'h4000_0000; issue_dst = 5'd10;
        @(negedge cpu_clk);
        chk("b2b_mul_sel", 32'(alu_sel), 32'd1);
        tick(); tick(); tick();
        issue_valid = 1'b0;
        tick(); tick(); tick();
        chk("b2b_pulses", 32'(wb_times.size()), 32'd2);
        if (wb_times.size() == 2) chk("b2b_spacing", 32'(wb_times[1] - wb_times[0]), 32'd2);

        // Illegal selector
        issue(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12);
        @(negedge cpu_clk);
        chk("ill_wb_valid", 32'(wb_valid), 32'd1);
        chk("ill_flag", 32'(illegal_op), 32'd1);
        chk("ill_wb_data", wb_data, 32'h7FC0_0000);
        chk("ill_busy", 32'(busy), 32'd0);
        tick(); tick();

        // Flush mid-sqrt together with a competing issue
        wb_times.delete();
        issue(3'd3, 32'h4080_0000, 32'h0, 5'd15);
        tick(); tick(); tick(); tick();
        flush = 1'b1; issue_valid = 1'b1; issue_op = 3'd0; issue_dst = 5'd20;
        issue_a = 32'h3F80_0000; issue_b = 32'h4000_0000;
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("flush_no_wb", 32'(wb_times.size()), 32'd0);
        chk("flush_idle", 32'(busy), 32'd0);
        issue(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd21);
        wait_wb(4, got);
        chk("post_flush_wb", 32'(got), 32'd1);
        chk("post_flush_addr", 32'(wb_addr), 32'd21);
        tick();

        // Reset mid-EXEC discards the op
        wb_times.delete();
        issue(3'd2, 32'h40C0_0000, 32'h4000_0000, 5'd2);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("rst_mid_no_wb", 32'(wb_times.size()), 32'd0);

`ifdef FPU_SEQ_FLAGS_EN
        issue(3'd1, 32'h7F00_0000, 32'h4000_0000, 5'd1);
        wait_wb(6, got);
        chk("flg_mul_wb", 32'(got), 32'd1);
        chk("flg_mul_data", wb_data, 32'h7F80_0000);
        chk("flg_mul_flags", 32'(flags), 32'b0100);
        tick();
        issue(3'd3, 32'hBF80_0000, 32'h0, 5'd2);
        wait_wb(20, got);
        chk("flg_sqrt_wb", 32'(got), 32'd1);
        chk("flg_sqrt_invalid", 32'(flags[3]), 32'd1);
        tick();
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
